// File: rtl/multdiv_unit.sv
// multdiv_unit: sequential shift-add multiplier / restoring divider that owns the HI/LO registers.
// Latency: done pulses WIDTH+2 edges after start (2 edges for a zero divisor); start is ignored while busy.
// Optional MULTDIV_UNSIGNED_EN: op[1] selects MULTU/DIVU; without it every op is signed.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DZ} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div, r_neg_q, r_neg_r;
    logic [WIDTH-1:0]   r_mcand, r_hw, r_lw;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_busy, r_done, r_dz;

    logic               w_load, w_iter, w_fin, w_dz_fin;
    logic               w_rs_neg, w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag, w_rt_mag;

`ifdef MULTDIV_UNSIGNED_EN
    logic w_signed;
    assign w_signed = ~op[1];
    assign w_rs_neg = w_signed & rs_val[WIDTH-1];
    assign w_rt_neg = w_signed & rt_val[WIDTH-1];
`else
    logic w_unused_op1;
    assign w_unused_op1 = op[1];
    assign w_rs_neg     = rs_val[WIDTH-1];
    assign w_rt_neg     = rt_val[WIDTH-1];
`endif
    assign w_rs_mag = w_rs_neg ? -rs_val : rs_val;
    assign w_rt_mag = w_rt_neg ? -rt_val : rt_val;

    // One shift-add step: low half holds the remaining multiplier bits.
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul;
    assign w_sum = {1'b0, r_hw} + {1'b0, r_mcand};
    assign w_mul = r_lw[0] ? {w_sum, r_lw[WIDTH-1:1]} : {1'b0, r_hw, r_lw[WIDTH-1:1]};

    // One restoring step: high half is the remainder, low half shifts dividend out / quotient in.
    logic [WIDTH:0]     w_shift, w_diff;
    logic [WIDTH-1:0]   w_div_hw, w_div_lw;
    assign w_shift  = {r_hw, r_lw[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_mcand};
    assign w_div_hw = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_div_lw = {r_lw[WIDTH-2:0], ~w_diff[WIDTH]};

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;
    assign w_prod = r_neg_q ? -{r_hw, r_lw} : {r_hw, r_lw};
    assign w_quo  = r_neg_q ? -r_lw : r_lw;
    assign w_rem  = r_neg_r ? -r_hw : r_hw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (op[0] && rt_val == '0) ? S_DZ : S_RUN;
            S_RUN:   if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            S_DZ:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_iter   = 1'b0;
        w_fin    = 1'b0;
        w_dz_fin = 1'b0;
        case (r_state)
            S_IDLE:  w_load   = start;
            S_RUN:   w_iter   = 1'b1;
            S_FIX:   w_fin    = 1'b1;
            S_DZ:    w_dz_fin = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_mcand  <= '0;
            r_hw     <= '0;
            r_lw     <= '0;
        end else if (w_load) begin
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_is_div <= op[0];
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
            r_hw     <= '0;
            r_mcand  <= op[0] ? w_rt_mag : w_rs_mag;
            r_lw     <= op[0] ? w_rs_mag : w_rt_mag;
        end else if (w_iter) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_is_div) begin
                r_hw <= w_div_hw;
                r_lw <= w_div_lw;
            end else begin
                {r_hw, r_lw} <= w_mul;
            end
        end
    end

    // Direct HI/LO writes only land in IDLE; a finishing op always wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fin) begin
            if (r_is_div) begin
                r_hi <= w_rem;
                r_lo <= w_quo;
            end else begin
                {r_hi, r_lo} <= w_prod;
            end
        end else if (r_state == S_IDLE) begin
            if (hi_wr) r_hi <= wdata;
            if (lo_wr) r_lo <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            if (w_load)                r_busy <= 1'b1;
            else if (w_fin | w_dz_fin) r_busy <= 1'b0;
            r_done <= w_fin | w_dz_fin;
            r_dz   <= w_dz_fin;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit (WIDTH=32): vector table plus hand sequences for reset, divide-by-zero and busy-time inputs.
module tb_multdiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         hi_wr = 1'b0;
    logic         lo_wr = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    multdiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drives one op at a negedge; returns edges until done (edge 1 = start sampling edge).
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic wh, input logic [W-1:0] wd,
                          output int lat, output logic busy1, output logic [W-1:0] hi1);
        @(negedge clk);
        op = o; rs_val = a; rt_val = b; start = 1'b1; hi_wr = wh; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; hi_wr = 1'b0;
        busy1 = busy; hi1 = hi; lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] rs, rt, ehi, elo;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int          lat;
        logic        b1;
        logic [W-1:0] h1;
        int          pulses;

        vecs[0]  = '{"mult_neg3x7",   2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{"mult_2p16sq",   2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[2]  = '{"mult_minsq",    2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{"mult_6xneg1",   2'b00, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[4]  = '{"div_neg7by2",   2'b01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5]  = '{"div_7byneg2",   2'b01, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6]  = '{"div_100by7",    2'b01, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[7]  = '{"div_overflow",  2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8]  = '{"div_3by5",      2'b01, 32'd3,        32'd5,        32'h00000003, 32'h00000000};
        vecs[9]  = '{"div_neg8byneg3",2'b01, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
        vecs[10] = '{"divu_7by2",     2'b11, 32'd7,        32'd2,        32'h00000001, 32'h00000003};
`ifdef MULTDIV_UNSIGNED_EN
        vecs[11] = '{"multu_big",     2'b10, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB};
        vecs[12] = '{"divu_big",      2'b11, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
`else
        vecs[11] = '{"op10_signed",   2'b10, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[12] = '{"op11_signed",   2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
`endif

        // Reset state
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz",   {63'd0, div_zero}, 64'd0);
        chk("rst_hi",   {32'd0, hi}, 64'd0);
        chk("rst_lo",   {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, '0, lat, b1, h1);
            chk({vecs[i].name, "_busy1"}, {63'd0, b1}, 64'd1);
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'd34);
            chk({vecs[i].name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
            chk({vecs[i].name, "_dz"}, {63'd0, div_zero}, 64'd0);
            chk({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].ehi});
            chk({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].elo});
            @(negedge clk);
            chk({vecs[i].name, "_done_clr"}, {63'd0, done}, 64'd0);
        end

        // Divide by zero keeps HI/LO
        @(negedge clk);
        hi_wr = 1'b1; wdata = 32'h11;
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b1; wdata = 32'h22;
        @(negedge clk);
        lo_wr = 1'b0;
        chk("mthi", {32'd0, hi}, 64'h11);
        chk("mtlo", {32'd0, lo}, 64'h22);
        run_op(2'b01, 32'd5, 32'd0, 1'b0, '0, lat, b1, h1);
        chk("dz_lat", 64'(lat), 64'd2);
        chk("dz_flag", {63'd0, div_zero}, 64'd1);
        chk("dz_busy", {63'd0, busy}, 64'd0);
        chk("dz_hi", {32'd0, hi}, 64'h11);
        chk("dz_lo", {32'd0, lo}, 64'h22);
        @(negedge clk);
        chk("dz_flag_clr", {63'd0, div_zero}, 64'd0);
        chk("dz_done_clr", {63'd0, done}, 64'd0);

        // hi_wr with start in IDLE: write lands, result overwrites at done
        run_op(2'b01, 32'd100, 32'd7, 1'b1, 32'h55, lat, b1, h1);
        chk("wrstart_hi_edge1", {32'd0, h1}, 64'h55);
        chk("wrstart_hi_done", {32'd0, hi}, 64'h2);

        // start and hi_wr/lo_wr during RUN are ignored
        @(negedge clk);
        op = 2'b00; rs_val = 32'hFFFFFFF9; rt_val = 32'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b01; rs_val = 32'd9; rt_val = 32'd0;
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hAA;
        @(negedge clk);
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        chk("busy_hi_ignored", {32'd0, hi}, 64'h2);
        chk("busy_lo_ignored", {32'd0, lo}, 64'hE);
        lat = 6; pulses = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("busy_ign_lat", 64'(lat), 64'd34);
        chk("busy_ign_hi", {32'd0, hi}, 64'hFFFFFFFF);
        chk("busy_ign_lo", {32'd0, lo}, 64'hFFFFFFF2);
        chk("busy_ign_dz", {63'd0, div_zero}, 64'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("busy_ign_single_done", 64'(pulses), 64'd0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        op = 2'b00; rs_val = 32'd3; rt_val = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_hi", {32'd0, hi}, 64'd0);
        chk("arst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("arst_no_done", 64'(pulses), 64'd0);
        chk("arst_idle_busy", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
